cordic_rotator: RTL and testbench

- Iterative CORDIC engine in rotation mode. Rotates vector (x_i, y_i) by angle z_i.
- Sits directly downstream of the arctangent ROM:
  - drives the ROM address with its iteration counter;
  - consumes the ROM's Q8.8-degree atan(2^-i) constant on the same cycle.
- One iteration per clock, 16 iterations per operation. Start/done handshake toward the control path.

---
 rtl/cordic_rotator.sv | 147 ++++++++++++++
 tb/tb_cordic_rotator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, angle constants from an external atan ROM.
// Optional gain compensation (SCALE state, x,y * 1/K) is built when CORDIC_GAIN_COMP_EN is defined.
module cordic_rotator #(
  parameter int Width = 16,
  parameter int Iters = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic signed [Width-1:0] x_i,
  input  logic signed [Width-1:0] y_i,
  input  logic signed [Width-1:0] z_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic signed [Width-1:0] x_o,
  output logic signed [Width-1:0] y_o,
  output logic signed [Width-1:0] z_o,
  output logic [3:0]              rom_addr_o,
  input  logic signed [Width-1:0] rom_data_i
);
  localparam int XW = Width + 2;
  localparam int ZW = Width + 1;
  localparam logic [3:0] LastIter = 4'(Iters - 1);
  localparam logic signed [ZW-1:0] ZMax = ZW'(23040);  // +90.0 degrees in Q8.8

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE, DONE} state_e;

  localparam int PW = XW + Width;
  localparam logic signed [Width-1:0] InvK = Width'(19898);  // 1/K in Q0.15

  function automatic logic signed [XW-1:0] scale_xy(input logic signed [XW-1:0] v);
    logic signed [PW-1:0] prod;
    prod = PW'(v) * PW'(InvK) + PW'(1 <<< 14);
    scale_xy = XW'(prod >>> 15);
  endfunction
`else
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;
`endif

  function automatic logic signed [Width-1:0] sat_xy(input logic signed [XW-1:0] v);
    if (&v[XW-1:Width-1] || ~|v[XW-1:Width-1]) sat_xy = v[Width-1:0];
    else if (v[XW-1]) sat_xy = {1'b1, {(Width-1){1'b0}}};
    else sat_xy = {1'b0, {(Width-1){1'b1}}};
  endfunction

  function automatic logic signed [ZW-1:0] clamp_z(input logic signed [Width-1:0] z);
    logic signed [ZW-1:0] ze;
    ze = ZW'(z);
    if (ze > ZMax) clamp_z = ZMax;
    else if (ze < -ZMax) clamp_z = -ZMax;
    else clamp_z = ze;
  endfunction

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    ready_q, done_q;
  logic signed [Width-1:0] xo_q, yo_q, zo_q;
  logic signed [XW-1:0]    x_q, y_q, x_d, y_d, x_sh, y_sh;
  logic signed [ZW-1:0]    z_q, z_d, rom_ext;

  assign x_sh    = x_q >>> cnt_q;
  assign y_sh    = y_q >>> cnt_q;
  assign rom_ext = ZW'(rom_data_i);

  // One micro-rotation; the sign of the residual angle picks the direction.
  always_comb begin
    if (z_q[ZW-1]) begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + rom_ext;
    end else begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - rom_ext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            xo_q   <= sat_xy(x_q);
            yo_q   <= sat_xy(y_q);
            zo_q   <= z_q[Width-1:0];
            done_q <= 1'b1;
          end
          if (start_i) begin
            x_q     <= XW'(x_i);
            y_q     <= XW'(y_i);
            z_q     <= clamp_z(z_i);
            cnt_q   <= '0;
            state_q <= ROTATE;
            ready_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        ROTATE: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (cnt_q == LastIter) begin
`ifdef CORDIC_GAIN_COMP_EN
            state_q <= SCALE;
`else
            state_q <= DONE;
            ready_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: begin
          x_q     <= scale_xy(x_q);
          y_q     <= scale_xy(y_q);
          state_q <= DONE;
          ready_q <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign x_o        = xo_q;
  assign y_o        = yo_q;
  assign z_o        = zo_q;
  assign rom_addr_o = cnt_q;
endmodule

// File: tb/tb_cordic_rotator.sv
// Directed bench for cordic_rotator with a behavioural atan ROM (Q8.8 degrees).
// Expected values follow CORDIC_GAIN_COMP_EN when the bench is built with it.
module tb_cordic_rotator;
  logic               clk = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic signed [15:0] x_i, y_i, z_i;
  logic               ready_o, done_o;
  logic signed [15:0] x_o, y_o, z_o;
  logic [3:0]         rom_addr_o;
  logic signed [15:0] rom_data_i;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int ExpLat = 18;
  localparam int Mag    = 8192;   // 8192 rotated, gain removed
  localparam int AX     = 4308;   // 4975*cos30
  localparam int AY     = 2487;   // 4975*sin30
  localparam int SatTol = 16;
`else
  localparam int ExpLat = 17;
  localparam int Mag    = 13490;  // 8192*K
  localparam int AX     = 7094;
  localparam int AY     = 4096;
  localparam int SatTol = 0;
`endif

  cordic_rotator #(.Width(16), .Iters(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .x_i(x_i), .y_i(y_i), .z_i(z_i),
    .ready_o(ready_o), .done_o(done_o),
    .x_o(x_o), .y_o(y_o), .z_o(z_o),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] atan_rom(input logic [3:0] a);
    case (a)
      4'd0:  return 16'sd11520;
      4'd1:  return 16'sd6801;
      4'd2:  return 16'sd3593;
      4'd3:  return 16'sd1824;
      4'd4:  return 16'sd916;
      4'd5:  return 16'sd458;
      4'd6:  return 16'sd229;
      4'd7:  return 16'sd115;
      4'd8:  return 16'sd57;
      4'd9:  return 16'sd29;
      4'd10: return 16'sd14;
      4'd11: return 16'sd7;
      4'd12: return 16'sd4;
      4'd13: return 16'sd2;
      4'd14: return 16'sd1;
      default: return 16'sd0;
    endcase
  endfunction

  assign rom_data_i = atan_rom(rom_addr_o);

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_tests++;
    if (got > exp + tol || got < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Starts one operation and returns the number of edges from the accepting edge to done_o.
  // poke_at > 0 re-asserts start_i with other operands after that many edges.
  task automatic run_op(input int xi, input int yi, input int zi, input int poke_at,
                        input bit b2b, output int lat);
    if (!b2b) @(negedge clk);
    x_i = 16'(xi); y_i = 16'(yi); z_i = 16'(zi); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (done_o) begin
        lat = n;
        break;
      end
      if (n == poke_at) begin
        check("ready_busy", int'(ready_o), 0, 0);
        x_i = 16'sd1000; y_i = 16'sd500; z_i = 16'sh1E00; start_i = 1'b1;
      end
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int ex, input int ey,
                           input int tol);
    check({tag, "_lat"}, lat, ExpLat, 0);
    check({tag, "_x"}, int'(x_o), ex, tol);
    check({tag, "_y"}, int'(y_o), ey, tol);
    check({tag, "_z"}, int'(z_o), 0, 1);
  endtask

  initial begin
    int lat;
    int found;
    int seen;

    rst_ni = 1'b0; start_i = 1'b1;
    x_i = 16'sd1234; y_i = 16'sd567; z_i = 16'sh1E00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(ready_o), 1, 0);
    check("rst_done", int'(done_o), 0, 0);
    check("rst_x", int'(x_o), 0, 0);
    check("rst_y", int'(y_o), 0, 0);
    check("rst_z", int'(z_o), 0, 0);
    check("rst_addr", int'(rom_addr_o), 0, 0);
    start_i = 1'b0;
    rst_ni  = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", int'(ready_o), 1, 0);

    run_op(4975, 0, 16'sh1E00, 0, 1'b0, lat);
    check_res("rot30", lat, AX, AY, 16);
    @(posedge clk); #1;
    check("done_pulse", int'(done_o), 0, 0);

    run_op(8192, 0, 16'shA600, 0, 1'b0, lat);
    check_res("neg90", lat, 0, -Mag, 16);

    run_op(8192, 0, 16'sh5A00, 0, 1'b0, lat);
    check_res("pos90", lat, 0, Mag, 16);

    run_op(8192, 0, 16'sh7000, 0, 1'b0, lat);
    check_res("clamp_hi", lat, 0, Mag, 16);

    run_op(8192, 0, 16'sh8000, 0, 1'b0, lat);
    check_res("clamp_lo", lat, 0, -Mag, 16);

    run_op(32767, 32767, 0, 0, 1'b0, lat);
    check_res("sat_pos", lat, 32767, 32767, SatTol);

    run_op(-32768, -32768, 0, 0, 1'b0, lat);
    check_res("sat_neg", lat, -32768, -32768, SatTol);

    run_op(8192, 0, 16'shA600, 5, 1'b0, lat);
    check_res("poke", lat, 0, -Mag, 16);

    run_op(4975, 0, 16'sh1E00, 0, 1'b0, lat);
    check_res("b2b_first", lat, AX, AY, 16);
    run_op(8192, 0, 16'sh5A00, 0, 1'b1, lat);
    check_res("b2b_second", lat, 0, Mag, 16);

    @(negedge clk);
    x_i = 16'sd8192; y_i = 16'sd0; z_i = 16'shA600; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    found = 0;
    for (int n = 0; n < 30; n++) begin
      if (rom_addr_o == 4'd7) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("iter7_reached", found, 1, 0);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    check("mid_rst_ready", int'(ready_o), 1, 0);
    check("mid_rst_done", int'(done_o), 0, 0);
    check("mid_rst_x", int'(x_o), 0, 0);
    check("mid_rst_y", int'(y_o), 0, 0);
    check("mid_rst_z", int'(z_o), 0, 0);
    check("mid_rst_addr", int'(rom_addr_o), 0, 0);
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done_o) seen = 1;
    end
    check("mid_rst_no_done", seen, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
